// File: rtl/fetch_unit.sv
// Instruction fetch PC sequencer: relative branches, absolute calls and returns
// through a circular return-address stack with sticky overflow/underflow flags.
module fetch_unit #(
  parameter int                ADDR_W    = 32,
  parameter int                RAS_DEPTH = 8,
  parameter int                BR_ADJ    = 3,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       branch,
  input  logic [ADDR_W-1:0]          branch_offset,
  input  logic                       call,
  input  logic [ADDR_W-1:0]          call_target,
  input  logic [ADDR_W-1:0]          call_return,
  input  logic                       ret,
  output logic [ADDR_W-1:0]          pc,
  output logic                       redirect,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_overflow,
  output logic                       ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] BR_ADJ_V = ADDR_W'(BR_ADJ);
  localparam logic [CNT_W-1:0]  FULL_V   = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              redirect_reg, redirect_next;
  logic [PTR_W-1:0]  top_reg, top_next, top_prev;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              ovf_reg, ovf_next;
  logic              udf_reg, udf_next;
  logic              push;

  // top_reg addresses the next free slot; once full it also addresses the oldest entry,
  // so a push into a full stack naturally overwrites the oldest return address.
  assign top_prev = top_reg - PTR_W'(1);

  always_comb begin
    pc_next       = pc_reg + ADDR_W'(1);
    redirect_next = 1'b0;
    top_next      = top_reg;
    count_next    = count_reg;
    ovf_next      = ovf_reg;
    udf_next      = udf_reg;
    push          = 1'b0;
    if (branch) begin
      pc_next       = pc_reg + branch_offset - BR_ADJ_V;
      redirect_next = 1'b1;
    end else if (call) begin
      pc_next       = call_target;
      redirect_next = 1'b1;
      push          = 1'b1;
      top_next      = top_reg + PTR_W'(1);
      if (count_reg == FULL_V) begin
        ovf_next = 1'b1;
      end else begin
        count_next = count_reg + CNT_W'(1);
      end
    end else if (ret) begin
      redirect_next = 1'b1;
      if (count_reg == '0) begin
        pc_next  = RESET_PC;
        udf_next = 1'b1;
      end else begin
        pc_next    = ras_mem[top_prev];
        top_next   = top_prev;
        count_next = count_reg - CNT_W'(1);
      end
    end else if (stall) begin
      pc_next = pc_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg       <= RESET_PC;
      redirect_reg <= 1'b0;
      top_reg      <= '0;
      count_reg    <= '0;
      ovf_reg      <= 1'b0;
      udf_reg      <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      redirect_reg <= redirect_next;
      top_reg      <= top_next;
      count_reg    <= count_next;
      ovf_reg      <= ovf_next;
      udf_reg      <= udf_next;
    end
  end

  // Entry storage is deliberately left out of reset; the count alone defines validity.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      ras_mem[top_reg] <= call_return;
    end
  end

  assign pc            = pc_reg;
  assign redirect      = redirect_reg;
  assign ras_count     = count_reg;
  assign ras_overflow  = ovf_reg;
  assign ras_underflow = udf_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, all checked against
// a queue-based return-stack model updated once per clock.
module tb_fetch_unit;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 8;
  localparam int BR_ADJ = 3;
  localparam logic [ADDR_W-1:0] RPC = '0;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stall = 1'b0, branch = 1'b0, call = 1'b0, ret = 1'b0;
  logic [ADDR_W-1:0] branch_offset = '0, call_target = '0, call_return = '0;
  logic [ADDR_W-1:0] pc;
  logic              redirect, ras_overflow, ras_underflow;
  logic [3:0]        ras_count;

  fetch_unit #(.ADDR_W(ADDR_W), .RAS_DEPTH(DEPTH), .BR_ADJ(BR_ADJ), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .branch_offset(branch_offset),
    .call(call), .call_target(call_target), .call_return(call_return), .ret(ret),
    .pc(pc), .redirect(redirect), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_txn = 0;

  logic [ADDR_W-1:0] m_pc = RPC;
  logic              m_red = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
  logic [ADDR_W-1:0] m_stack [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc  = RPC;
    m_red = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_stack.delete();
  endtask

  task automatic check_all();
    check_val("pc", pc, m_pc);
    check_val("redirect", 32'(redirect), 32'(m_red));
    check_val("ras_count", 32'(ras_count), m_stack.size());
    check_val("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
    check_val("ras_underflow", 32'(ras_underflow), 32'(m_udf));
  endtask

  // Apply one cycle of inputs, advance the model, then sample 1 time unit after the edge.
  task automatic step(input logic b, input logic [ADDR_W-1:0] off, input logic c,
                      input logic [ADDR_W-1:0] tgt, input logic [ADDR_W-1:0] ra,
                      input logic r, input logic s);
    branch = b; branch_offset = off; call = c; call_target = tgt; call_return = ra;
    ret = r; stall = s;
    @(posedge clk);
    m_red = b | c | r;
    if (b) begin
      m_pc = m_pc + off - ADDR_W'(BR_ADJ);
    end else if (c) begin
      m_pc = tgt;
      m_stack.push_back(ra);
      if (m_stack.size() > DEPTH) begin
        void'(m_stack.pop_front());
        m_ovf = 1'b1;
      end
    end else if (r) begin
      if (m_stack.size() == 0) begin
        m_pc  = RPC;
        m_udf = 1'b1;
      end else begin
        m_pc = m_stack.pop_back();
      end
    end else if (!s) begin
      m_pc = m_pc + 1;
    end
    #1;
    n_txn++;
    $display("txn %0d b=%0b c=%0b r=%0b s=%0b -> pc=%08h red=%0b cnt=%0d ovf=%0b udf=%0b",
             n_txn, b, c, r, s, pc, redirect, ras_count, ras_overflow, ras_underflow);
    check_all();
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check_val("rst_pc", pc, 32'h0);
    #4 rst = 1'b0;

    // Idle increments from reset
    for (int i = 1; i <= 5; i++) begin
      idle();
      check_val("idle_pc", pc, i);
      check_val("idle_red", 32'(redirect), 32'h0);
    end

    // Relative branches, forward and backward
    while (m_pc != 10) idle();
    step(1'b1, 32'd8, 1'b0, '0, '0, 1'b0, 1'b0);
    check_val("br_fwd", pc, 32'd15);
    check_val("br_red", 32'(redirect), 32'h1);
    idle();
    check_val("br_red_pulse", 32'(redirect), 32'h0);
    while (m_pc != 20) idle();
    step(1'b1, -32'sd4, 1'b0, '0, '0, 1'b0, 1'b0);
    check_val("br_back", pc, 32'd13);

    // Call, two increments, return
    step(1'b0, '0, 1'b1, 32'h100, 32'h21, 1'b0, 1'b0);
    check_val("call_pc", pc, 32'h100);
    check_val("call_cnt", 32'(ras_count), 32'h1);
    idle();
    idle();
    check_val("call_inc", pc, 32'h102);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
    check_val("ret_pc", pc, 32'h21);
    check_val("ret_cnt", 32'(ras_count), 32'h0);

    // Overflow with 9 calls, then drain with 9 returns
    for (int i = 1; i <= 9; i++) step(1'b0, '0, 1'b1, 32'h200 + i, i, 1'b0, 1'b0);
    check_val("ovf_flag", 32'(ras_overflow), 32'h1);
    check_val("ovf_cnt", 32'(ras_count), DEPTH);
    for (int i = 9; i >= 2; i--) begin
      step(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
      check_val("ovf_ret_pc", pc, i);
    end
    check_val("pre_udf", 32'(ras_underflow), 32'h0);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
    check_val("udf_pc", pc, 32'h0);
    check_val("udf_flag", 32'(ras_underflow), 32'h1);

    // Priority: branch over call over ret; stall hold; redirect through stall
    step(1'b0, '0, 1'b1, 32'h300, 32'h55, 1'b0, 1'b0);
    step(1'b1, 32'h10, 1'b1, 32'h400, 32'h66, 1'b1, 1'b0);
    check_val("prio_pc", pc, 32'h300 + 32'h10 - BR_ADJ);
    check_val("prio_cnt", 32'(ras_count), 32'h1);
    step(1'b0, '0, 1'b1, 32'h500, 32'h77, 1'b1, 1'b0);
    check_val("call_ret_pc", pc, 32'h500);
    check_val("call_ret_cnt", 32'(ras_count), 32'h2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
      check_val("stall_pc", pc, 32'h500);
    end
    step(1'b0, '0, 1'b1, 32'h600, 32'h88, 1'b0, 1'b1);
    check_val("stall_call_pc", pc, 32'h600);

    // Increment wraps at 2^ADDR_W
    step(1'b0, '0, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    idle();
    check_val("wrap_pc", pc, 32'h0);

    // Asynchronous reset mid-cycle with ras_count == 3
    model_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 32'h700 + i, 32'h40 + i, 1'b0, 1'b0);
    check_val("pre_arst_cnt", 32'(ras_count), 32'h3);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_val("arst_pc", pc, 32'h0);
    check_val("arst_cnt", 32'(ras_count), 32'h0);
    check_val("arst_red", 32'(redirect), 32'h0);
    @(posedge clk);
    #5 rst = 1'b0;
    idle();
    check_val("post_rst_pc", pc, 32'h1);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
    check_val("post_rst_udf", 32'(ras_underflow), 32'h1);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic rb, rc, rr, rs;
      logic [ADDR_W-1:0] roff, rtgt, rra;
      rb   = ($urandom_range(0, 99) < 10);
      rc   = ($urandom_range(0, 99) < 20);
      rr   = ($urandom_range(0, 99) < 20);
      rs   = ($urandom_range(0, 99) < 25);
      roff = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom()) : ADDR_W'($urandom_range(0, 64)) - 32;
      rtgt = ADDR_W'($urandom());
      rra  = ADDR_W'($urandom());
      step(rb, roff, rc, rtgt, rra, rr, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
